pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register enable and flush strobes for load-use stalls, taken-branch flushes, multi-cycle data-memory waits and program halt.
- Keeps cycle, stall and flush performance counters.
- Sits beside the datapath. Flush strobes are ORed into the target register's synchronous reset.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles in MEM_WAIT before mem_err.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- idex_memread  in  1  instruction in ID/EX is a load
- idex_rt  in  5  destination rt of instruction in ID/EX
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- mem_req  in  1  EX/MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- wb_halt  in  1  halt instruction is in MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  bubble insert (ORed into register reset)
- pc_sel_branch  out  1  PC loads branch target instead of PC+4
- halted  out  1  pipeline stopped after halt
- mem_err  out  1  memory timeout occurred (sticky)
- cycle_count, stall_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- States (registered): RUN, MEM_WAIT, HALTED.
- Enables and flushes are combinational from state and inputs so hazards act in the same cycle.
- Reset: state=RUN, all counters=0, halted=0, mem_err=0, wait counter=0.
- While reset is high: all enables=1, flushes=0, pc_sel_branch=0.
- Priority, highest first: reset > HALTED > memory wait > branch flush > load-use stall.

RUN state:
- Memory wait (mem_req & !mem_ready):
  - All five enables=0, flushes=0.
  - Next state MEM_WAIT; wait counter := 1.
- Else if ex_branch_taken:
  - All enables=1, pc_sel_branch=1, ifid_flush=1, idex_flush=1.
  - flush_count += 1.
  - Branch overrides a simultaneous load-use stall.
- Else if load-use hazard:
  - Condition: idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
  - pc_en=0, ifid_en=0, idex_flush=1; the rest are enabled.
  - stall_count += 1.
  - Lasts exactly one cycle, because the bubble clears idex_memread.
- Else: all enables=1, no flush.
- If wb_halt (and no memory wait): next state HALTED. The MEM/WB write in this cycle still completes.

MEM_WAIT state:
- Whole pipeline frozen: all enables=0, flushes=0. stall_count += 1 per cycle.
- ex_branch_taken is ignored; it is held in EX/MEM and acted on after release.
- If mem_ready:
  - Enables=1 this cycle, next state RUN, wait counter := 0.
  - Branch and load-use rules do not apply on this release cycle.
  - They re-evaluate in RUN next cycle.
- Else if wait counter == MEM_TIMEOUT: mem_err := 1, next state HALTED.
- Else wait counter += 1.

HALTED state:
- All enables=0, halted=1. Remains until reset.

Counters:
- cycle_count += 1 every non-reset cycle except in HALTED.
- All counters saturate at all-ones; no wrap.
- stall_count counts RUN load-use cycles and MEM_WAIT cycles.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - State encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2).
  - Register-index constants for the enable vector.
  - Default MEM_TIMEOUT.
- One sub-module, sat_counter: CNT_W-bit saturating counter with sync reset and increment input. Instantiated three times.

Test Plan:
- Reset, then 10 idle cycles (no hazards) -> all enables=1, flushes=0, cycle_count=10, stall_count=0.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle. stall_count=1. Same inputs with idex_rt=0 -> no stall.
- Branch plus load-use in the same cycle -> pc_sel_branch=1, ifid_flush=idex_flush=1, pc_en=1, flush_count=1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> enables=0 for 3 cycles, then all 1, state RUN, stall_count=3.
- Timeout: mem_req=1, mem_ready held 0 -> mem_err=1 and halted=1 after MEM_TIMEOUT+1 wait cycles. Enables stay 0; cycle_count freezes.
- wb_halt=1 in RUN -> halted=1 next cycle, all enables=0. Reset asserted mid-HALTED -> next cycle state RUN, counters 0, mem_err=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_e;

   // Bit positions inside the pipeline-register enable vector
   localparam int EN_PC    = 0;
   localparam int EN_IFID  = 1;
   localparam int EN_IDEX  = 2;
   localparam int EN_EXMEM = 3;
   localparam int EN_MEMWB = 4;
   localparam int NUM_REGS = 5;

   localparam int CNT_CYCLE = 0;
   localparam int CNT_STALL = 1;
   localparam int CNT_FLUSH = 2;
   localparam int NUM_CNTS  = 3;

   localparam int DEFAULT_MEM_TIMEOUT = 16;
   localparam int DEFAULT_CNT_W       = 32;

   // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
   function automatic logic load_use_hazard(
      input logic       memread,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       id_uses_rt
   );
      return memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs, register control strobes and performance counters between datapath and controller.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             idex_memread;
   logic [4:0]       idex_rt;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             wb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pc_sel_branch;
   logic             halted;
   logic             mem_err;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
             ex_branch_taken, mem_req, mem_ready, wb_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             pc_sel_branch, halted, mem_err, cycle_count, stall_count, flush_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
             ex_branch_taken, mem_req, mem_ready, wb_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             pc_sel_branch, halted, mem_err, cycle_count, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// 5-stage pipeline hazard controller: load-use stalls, branch flushes, data-memory waits, halt.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_stall_ctrl_if.slave  bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                mem_err_q, mem_err_d;

   logic [NUM_REGS-1:0] en;
   logic                ifid_flush, idex_flush, pc_sel_branch;
   logic [NUM_CNTS-1:0] cnt_inc;
   logic [CNT_W-1:0]    cnt_val [NUM_CNTS];
   logic                hazard, mem_wait;

   assign hazard   = load_use_hazard(bus.idex_memread, bus.idex_rt, bus.ifid_rs,
                                     bus.ifid_rt, bus.ifid_uses_rt);
   assign mem_wait = bus.mem_req && !bus.mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      mem_err_d     = mem_err_q;
      en            = '1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      pc_sel_branch = 1'b0;
      cnt_inc       = '0;
      if (!reset) begin
         unique case (state_q)
            ST_RUN: begin
               cnt_inc[CNT_CYCLE] = 1'b1;
               if (mem_wait) begin
                  en      = '0;
                  state_d = ST_MEM_WAIT;
                  wait_d  = WAIT_W'(1);
               end else begin
                  if (bus.ex_branch_taken) begin
                     pc_sel_branch      = 1'b1;
                     ifid_flush         = 1'b1;
                     idex_flush         = 1'b1;
                     cnt_inc[CNT_FLUSH] = 1'b1;
                  end else if (hazard) begin
                     en[EN_PC]          = 1'b0;
                     en[EN_IFID]        = 1'b0;
                     idex_flush         = 1'b1;
                     cnt_inc[CNT_STALL] = 1'b1;
                  end
                  // MEM/WB stays enabled so the halt instruction's own write lands.
                  if (bus.wb_halt) begin
                     state_d = ST_HALTED;
                  end
               end
            end
            ST_MEM_WAIT: begin
               cnt_inc[CNT_CYCLE] = 1'b1;
               cnt_inc[CNT_STALL] = 1'b1;
               en                 = '0;
               if (bus.mem_ready) begin
                  en      = '1;
                  state_d = ST_RUN;
                  wait_d  = '0;
               end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                  mem_err_d = 1'b1;
                  state_d   = ST_HALTED;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
            default: begin
               en = '0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_CNTS; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .srst  (reset),
         .inc_i (cnt_inc[gi]),
         .cnt_o (cnt_val[gi])
      );
   end

   assign bus.pc_en         = en[EN_PC];
   assign bus.ifid_en       = en[EN_IFID];
   assign bus.idex_en       = en[EN_IDEX];
   assign bus.exmem_en      = en[EN_EXMEM];
   assign bus.memwb_en      = en[EN_MEMWB];
   assign bus.ifid_flush    = ifid_flush;
   assign bus.idex_flush    = idex_flush;
   assign bus.pc_sel_branch = pc_sel_branch;
   assign bus.halted        = (state_q == ST_HALTED);
   assign bus.mem_err       = mem_err_q;
   assign bus.cycle_count   = cnt_val[CNT_CYCLE];
   assign bus.stall_count   = cnt_val[CNT_STALL];
   assign bus.flush_count   = cnt_val[CNT_FLUSH];
endmodule
